uart_fifo_transceiver: RTL and testbench

Parametrised full-duplex UART transceiver for slave-side serial links: a valid/ready byte interface drives `tx`, and an RX FIFO of configurable depth buffers words received on `rx`. Data width, parity mode, stop-bit count, baud rate and FIFO depth are parameters. Parity, framing and overflow errors are reported as one-cycle pulses. It replaces the fixed 8N1, single-buffer UART path inside the UART slave system.

---
 rtl/uart_fifo_transceiver.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_fifo_transceiver.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_transceiver.sv
// Full-duplex UART with a valid/ready transmit port and a receive FIFO.
// Word width, parity, stop bits, baud rate and FIFO depth are parameters.
module uart_fifo_transceiver #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 19200,
   parameter int DATA_WIDTH = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rstN,
   input  logic [DATA_WIDTH-1:0]         tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          tx,
   input  logic                          rx,
   output logic [DATA_WIDTH-1:0]         rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   rx_level,
   output logic                          parity_err,
   output logic                          frame_err,
   output logic                          overflow
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
   localparam int CNT_W        = $clog2(STOP_CLKS + 1);
   localparam int IDX_W        = $clog2(DATA_WIDTH);
   localparam int AW           = $clog2(FIFO_DEPTH);
   localparam int LVL_W        = AW + 1;

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d);
      return (PARITY == 1) ? ~^d : ^d;
   endfunction

   // ---------------- transmitter ----------------
   state_t                tx_state, tx_state_nxt;
   logic [CNT_W-1:0]      tx_cnt, tx_cnt_nxt;
   logic [IDX_W-1:0]      tx_idx, tx_idx_nxt;
   logic [DATA_WIDTH-1:0] tx_shift, tx_shift_nxt;
   logic                  tx_par, tx_par_nxt;
   logic                  tx_q, tx_nxt;

   // NOTE: every signal gets a default at the top of always_comb so no path infers a latch.
   always_comb begin
      tx_state_nxt = tx_state;
      tx_cnt_nxt   = tx_cnt + 1'b1;
      tx_idx_nxt   = tx_idx;
      tx_shift_nxt = tx_shift;
      tx_par_nxt   = tx_par;
      tx_nxt       = tx_q;
      unique case (tx_state)
         S_IDLE: begin
            tx_cnt_nxt = '0;
            tx_nxt     = 1'b1;
            if (tx_valid) begin
               tx_state_nxt = S_START;
               tx_shift_nxt = tx_data;
               tx_par_nxt   = parity_of(tx_data);
               tx_idx_nxt   = '0;
               tx_nxt       = 1'b0;
            end
         end
         S_START: if (tx_cnt == BIT_LAST) begin
            tx_state_nxt = S_DATA;
            tx_cnt_nxt   = '0;
            tx_nxt       = tx_shift[0];
         end
         S_DATA: if (tx_cnt == BIT_LAST) begin
            tx_cnt_nxt = '0;
            if (tx_idx == IDX_LAST) begin
               tx_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
               tx_nxt       = (PARITY != 0) ? tx_par : 1'b1;
            end else begin
               tx_idx_nxt   = tx_idx + 1'b1;
               tx_shift_nxt = tx_shift >> 1;
               tx_nxt       = tx_shift[1];
            end
         end
         S_PARITY: if (tx_cnt == BIT_LAST) begin
            tx_state_nxt = S_STOP;
            tx_cnt_nxt   = '0;
            tx_nxt       = 1'b1;
         end
         S_STOP: if (tx_cnt == STOP_LAST) begin
            tx_state_nxt = S_IDLE;
            tx_cnt_nxt   = '0;
            tx_nxt       = 1'b1;
         end
         default: tx_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         tx_state <= S_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_shift <= '0;
         tx_par   <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         tx_state <= tx_state_nxt;
         tx_cnt   <= tx_cnt_nxt;
         tx_idx   <= tx_idx_nxt;
         tx_shift <= tx_shift_nxt;
         tx_par   <= tx_par_nxt;
         tx_q     <= tx_nxt;
      end
   end

   assign tx_ready = (tx_state == S_IDLE);
   assign tx       = tx_q;

   // ---------------- receiver ----------------
   logic                  rx_meta, rx_sync, rx_prev;
   state_t                rx_state, rx_state_nxt;
   logic [CNT_W-1:0]      rx_cnt, rx_cnt_nxt;
   logic [IDX_W-1:0]      rx_idx, rx_idx_nxt;
   logic [DATA_WIDTH-1:0] rx_shift, rx_shift_nxt;
   logic                  rx_par_bit, rx_par_bit_nxt;
   logic                  done_q, done_nxt;
   logic                  frame_bad_q, frame_bad_nxt;
   logic                  par_bad_q, par_bad_nxt;

   always_comb begin
      rx_state_nxt   = rx_state;
      rx_cnt_nxt     = rx_cnt + 1'b1;
      rx_idx_nxt     = rx_idx;
      rx_shift_nxt   = rx_shift;
      rx_par_bit_nxt = rx_par_bit;
      done_nxt       = 1'b0;
      frame_bad_nxt  = frame_bad_q;
      par_bad_nxt    = par_bad_q;
      unique case (rx_state)
         S_IDLE: begin
            rx_cnt_nxt = '0;
            if (rx_prev && !rx_sync) rx_state_nxt = S_START;
         end
         S_START: if (rx_cnt == HALF_LAST) begin
            rx_cnt_nxt   = '0;
            rx_idx_nxt   = '0;
            rx_state_nxt = rx_sync ? S_IDLE : S_DATA;
         end
         S_DATA: if (rx_cnt == BIT_LAST) begin
            rx_cnt_nxt   = '0;
            rx_shift_nxt = {rx_sync, rx_shift[DATA_WIDTH-1:1]};
            if (rx_idx == IDX_LAST) rx_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            else                    rx_idx_nxt   = rx_idx + 1'b1;
         end
         S_PARITY: if (rx_cnt == BIT_LAST) begin
            rx_cnt_nxt     = '0;
            rx_par_bit_nxt = rx_sync;
            rx_state_nxt   = S_STOP;
         end
         S_STOP: if (rx_cnt == BIT_LAST) begin
            // Only the first stop bit is checked; return to IDLE at once for back-to-back frames.
            rx_cnt_nxt    = '0;
            rx_state_nxt  = S_IDLE;
            done_nxt      = 1'b1;
            frame_bad_nxt = ~rx_sync;
            par_bad_nxt   = (PARITY != 0) && (rx_par_bit != parity_of(rx_shift));
         end
         default: rx_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         rx_meta     <= 1'b1;
         rx_sync     <= 1'b1;
         rx_prev     <= 1'b1;
         rx_state    <= S_IDLE;
         rx_cnt      <= '0;
         rx_idx      <= '0;
         rx_shift    <= '0;
         rx_par_bit  <= 1'b0;
         done_q      <= 1'b0;
         frame_bad_q <= 1'b0;
         par_bad_q   <= 1'b0;
      end else begin
         rx_meta     <= rx;
         rx_sync     <= rx_meta;
         rx_prev     <= rx_sync;
         rx_state    <= rx_state_nxt;
         rx_cnt      <= rx_cnt_nxt;
         rx_idx      <= rx_idx_nxt;
         rx_shift    <= rx_shift_nxt;
         rx_par_bit  <= rx_par_bit_nxt;
         done_q      <= done_nxt;
         frame_bad_q <= frame_bad_nxt;
         par_bad_q   <= par_bad_nxt;
      end
   end

   // ---------------- receive FIFO ----------------
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW:0]           wr_ptr, rd_ptr;
   logic [AW-1:0]         rd_idx_next;
   logic                  push, pop, full, wr_en;

   assign rx_level    = wr_ptr - rd_ptr;
   assign rx_valid    = (rx_level != '0);
   assign full        = (rx_level == LVL_W'(FIFO_DEPTH));
   assign push        = done_q & ~frame_bad_q & ~par_bad_q;
   assign pop         = rx_valid & rx_ready;
   assign wr_en       = push & (~full | pop);
   assign rd_idx_next = rd_ptr[AW-1:0] + AW'(1);

   // NOTE: storage array has no reset; validity is tracked solely by the pointers.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= rx_shift;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         rx_data    <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         // Head register: bypass the incoming word when it becomes the new head.
         if (wr_en && (rx_level == '0 || (pop && rx_level == LVL_W'(1))))
            rx_data <= rx_shift;
         else if (pop && rx_level > LVL_W'(1))
            rx_data <= mem[rd_idx_next];
         parity_err <= done_q & par_bad_q;
         frame_err  <= done_q & frame_bad_q;
         overflow   <= push & full & ~pop;
      end
   end

endmodule

// File: tb/tb_uart_fifo_transceiver.sv
// Self-checking bench: even-parity/1-stop instance (TX, loopback, RX errors, FIFO)
// and odd-parity/2-stop instance (TX framing with loopback).
module tb_uart_fifo_transceiver;

   localparam int CPB    = 16;
   localparam int NB_A   = 11;
   localparam int PUSH_C = 3 + CPB / 2 + 10 * CPB;

   logic clk = 1'b0;
   logic rstN;
   logic [7:0] tx_data_a, tx_data_b, rx_data_a, rx_data_b;
   logic tx_valid_a, tx_valid_b, tx_ready_a, tx_ready_b, tx_a, tx_b, rx_a, rx_b;
   logic rx_valid_a, rx_valid_b, rx_ready_a, rx_ready_b;
   logic [2:0] rx_level_a, rx_level_b;
   logic parity_err_a, frame_err_a, overflow_a, parity_err_b, frame_err_b, overflow_b;
   logic rx_drv, loop_a;

   int checks = 0;
   int errors = 0;
   int n_par = 0, n_frm = 0, n_ovf = 0, n_err_b = 0;
   logic [7:0] model[$];

   assign rx_a = loop_a ? tx_a : rx_drv;
   assign rx_b = tx_b;

   always #10 clk = ~clk;

   uart_fifo_transceiver #(
      .CLK_FREQ(50_000_000), .BAUD_RATE(3_125_000), .DATA_WIDTH(8),
      .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
   ) dut_a (
      .clk(clk), .rstN(rstN), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
      .tx_ready(tx_ready_a), .tx(tx_a), .rx(rx_a), .rx_data(rx_data_a),
      .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .rx_level(rx_level_a),
      .parity_err(parity_err_a), .frame_err(frame_err_a), .overflow(overflow_a)
   );

   uart_fifo_transceiver #(
      .CLK_FREQ(50_000_000), .BAUD_RATE(3_125_000), .DATA_WIDTH(8),
      .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)
   ) dut_b (
      .clk(clk), .rstN(rstN), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
      .tx_ready(tx_ready_b), .tx(tx_b), .rx(rx_b), .rx_data(rx_data_b),
      .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .rx_level(rx_level_b),
      .parity_err(parity_err_b), .frame_err(frame_err_b), .overflow(overflow_b)
   );

   always @(posedge clk) begin
      if (parity_err_a === 1'b1) n_par++;
      if (frame_err_a === 1'b1)  n_frm++;
      if (overflow_a === 1'b1)   n_ovf++;
      if ((parity_err_b | frame_err_b | overflow_b) === 1'b1) n_err_b++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Frame bit k of a word: start, data LSB first, parity (pmode 1 odd, 2 even), then stop ones.
   function automatic logic frame_bit(input logic [7:0] d, input int pmode, input int k);
      int ones;
      ones = $countones(d);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
      if (pmode != 0 && k == 9) return (pmode == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      return 1'b1;
   endfunction

   task automatic send_tx(input bit sel, input logic [7:0] d);
      int pm, nb, n, bad;
      pm = sel ? 1 : 2;
      nb = sel ? 12 : 11;
      n  = 0;
      while (((sel ? tx_ready_b : tx_ready_a) !== 1'b1) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("tx%0d_ready_before", sel), sel ? tx_ready_b : tx_ready_a, 1);
      if (sel) begin tx_data_b = d; tx_valid_b = 1'b1; end
      else     begin tx_data_a = d; tx_valid_a = 1'b1; end
      @(negedge clk);
      tx_valid_a = 1'b0;
      tx_valid_b = 1'b0;
      for (int b = 0; b < nb; b++) begin
         bad = 0;
         for (int c = 0; c < CPB; c++) begin
            if ((sel ? tx_b : tx_a) !== frame_bit(d, pm, b) ||
                (sel ? tx_ready_b : tx_ready_a) !== 1'b0) bad++;
            @(negedge clk);
         end
         check($sformatf("tx%0d_%02h_bit%0d_bad_cycles", sel, d, b), bad, 0);
      end
      check($sformatf("tx%0d_ready_after", sel), sel ? tx_ready_b : tx_ready_a, 1);
      check($sformatf("tx%0d_idle_after", sel), sel ? tx_b : tx_a, 1);
   endtask

   // Drives one even-parity frame on instance A's rx and checks the push-edge outcome.
   task automatic drive_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input bit pop_now);
      bit good, popped, full, exp_ovf;
      int k;
      for (int c = 0; c < NB_A * CPB + 6; c++) begin
         if (c == PUSH_C) begin
            check("rx_level_pre_push", rx_level_a, model.size());
            if (pop_now && model.size() > 0) begin
               check("rx_head_at_push", rx_data_a, model[0]);
               rx_ready_a = 1'b1;
            end
         end
         if (c == PUSH_C + 1) begin
            rx_ready_a = 1'b0;
            good    = !bad_par && !bad_stop;
            popped  = pop_now && model.size() > 0;
            full    = model.size() == 4;
            exp_ovf = good && full && !popped;
            if (popped) void'(model.pop_front());
            if (good && !exp_ovf) model.push_back(d);
            check($sformatf("parity_err_%02h", d), parity_err_a, bad_par);
            check($sformatf("frame_err_%02h", d), frame_err_a, bad_stop);
            check($sformatf("overflow_%02h", d), overflow_a, exp_ovf);
            check($sformatf("rx_level_post_%02h", d), rx_level_a, model.size());
         end
         if (c < NB_A * CPB) begin
            k = c / CPB;
            rx_drv = frame_bit(d, 2, k) ^ (k == 9 && bad_par) ^ (k == 10 && bad_stop);
         end else begin
            rx_drv = 1'b1;
         end
         @(negedge clk);
      end
   endtask

   task automatic pop_check(input string tag);
      logic [7:0] e;
      check({tag, "_valid"}, rx_valid_a, 1);
      if (model.size() > 0) begin
         e = model.pop_front();
         check({tag, "_data"}, rx_data_a, e);
      end
      rx_ready_a = 1'b1;
      @(negedge clk);
      rx_ready_a = 1'b0;
      check({tag, "_level"}, rx_level_a, model.size());
   endtask

   initial begin
      int base_par, base_frm, base_ovf;
      logic [7:0] w;
      rstN = 1'b0;
      tx_data_a = '0; tx_data_b = '0; tx_valid_a = 1'b0; tx_valid_b = 1'b0;
      rx_ready_a = 1'b0; rx_ready_b = 1'b0; rx_drv = 1'b1; loop_a = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_tx_a", tx_a, 1);
      check("rst_tx_ready_a", tx_ready_a, 1);
      check("rst_rx_valid_a", rx_valid_a, 0);
      check("rst_rx_data_a", rx_data_a, 0);
      check("rst_rx_level_a", rx_level_a, 0);
      check("rst_err_a", {parity_err_a, frame_err_a, overflow_a}, 0);
      check("rst_tx_b", tx_b, 1);
      check("rst_tx_ready_b", tx_ready_b, 1);
      rstN = 1'b1;
      repeat (2) @(negedge clk);

      // TX framing: even parity on A, odd parity with two stop bits on B
      send_tx(1'b0, 8'hA5);
      send_tx(1'b1, 8'hA5);
      check("b_loop_level", rx_level_b, 1);
      check("b_loop_data", rx_data_b, 8'hA5);
      for (int i = 0; i < 2; i++) send_tx(1'b0, 8'($urandom));

      // Back-to-back loopback on A
      base_par = n_par; base_frm = n_frm; base_ovf = n_ovf;
      loop_a = 1'b1;
      send_tx(1'b0, 8'h00); model.push_back(8'h00);
      send_tx(1'b0, 8'hFF); model.push_back(8'hFF);
      send_tx(1'b0, 8'h3C); model.push_back(8'h3C);
      repeat (10) @(negedge clk);
      loop_a = 1'b0;
      check("loop_level", rx_level_a, 3);
      check("loop_errs", (n_par - base_par) + (n_frm - base_frm) + (n_ovf - base_ovf), 0);
      pop_check("loop_pop0");
      pop_check("loop_pop1");
      pop_check("loop_pop2");
      check("loop_empty", rx_valid_a, 0);

      // Error injection and false start
      base_par = n_par; base_frm = n_frm;
      drive_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
      drive_frame(8'($urandom), 1'b0, 1'b1, 1'b0);
      drive_frame(8'($urandom), 1'b1, 1'b1, 1'b0);
      check("par_err_count", n_par - base_par, 2);
      check("frm_err_count", n_frm - base_frm, 2);
      rx_drv = 1'b0;
      repeat (5) @(negedge clk);
      rx_drv = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch_level", rx_level_a, 0);
      check("glitch_pulses", (n_par - base_par) + (n_frm - base_frm), 4);
      drive_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
      pop_check("direct_pop");

      // Overflow, then push and pop on the same edge while full
      base_ovf = n_ovf;
      for (int i = 0; i < 5; i++) drive_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
      check("ovf_level", rx_level_a, 4);
      check("ovf_count", n_ovf - base_ovf, 1);
      drive_frame(8'($urandom), 1'b0, 1'b0, 1'b1);
      check("full_pushpop_level", rx_level_a, 4);
      check("full_pushpop_ovf", n_ovf - base_ovf, 1);
      for (int i = 0; i < 4; i++) pop_check($sformatf("drain%0d", i));
      rx_ready_a = 1'b1;
      @(negedge clk);
      rx_ready_a = 1'b0;
      check("empty_pop_level", rx_level_a, 0);
      check("empty_pop_valid", rx_valid_a, 0);

      // Asynchronous reset in the middle of a TX frame with data buffered
      drive_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
      check("pre_rst_level", rx_level_a, 1);
      w = 8'($urandom);
      tx_data_a = w;
      tx_valid_a = 1'b1;
      @(negedge clk);
      tx_valid_a = 1'b0;
      repeat (50) @(negedge clk);
      check("mid_frame_busy", tx_ready_a, 0);
      #3 rstN = 1'b0;
      #1;
      check("async_rst_tx", tx_a, 1);
      check("async_rst_ready", tx_ready_a, 1);
      check("async_rst_level", rx_level_a, 0);
      check("async_rst_data", rx_data_a, 0);
      model.delete();
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      send_tx(1'b0, w);
      check("b_no_errors", n_err_b, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
